// File: rtl/com_fifo_rr_sched_if.sv
// Scheduler bundle: requester FIFO read side plus the tagged output port.
// master = scheduler, slave = FIFOs and downstream sink.
interface com_fifo_rr_sched_if #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int AW = 4,
   parameter int SW = 2
);
   logic [N-1:0]    fifo_empty;
   logic [N*AW-1:0] fifo_level;
   logic [N-1:0]    fifo_rd_en;
   logic [N*DW-1:0] fifo_rd_data;
   logic            out_vld;
   logic            out_rdy;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;

   modport master (
      input  fifo_empty,
      input  fifo_level,
      input  fifo_rd_data,
      input  out_rdy,
      output fifo_rd_en,
      output out_vld,
      output out_data,
      output out_src
   );

   modport slave (
      output fifo_empty,
      output fifo_level,
      output fifo_rd_data,
      output out_rdy,
      input  fifo_rd_en,
      input  out_vld,
      input  out_data,
      input  out_src
   );
endinterface

// File: rtl/com_fifo_rr_sched.sv
// Round-robin read scheduler over N sync FIFOs with bursts and urgent
// watermark priority; returned words go through a 2-entry output buffer.
module com_fifo_rr_sched #(
   parameter int N     = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH+1),
   parameter int SW    = $clog2(N),
   parameter int HI_WM = DEPTH-2,
   parameter int BURST = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   com_fifo_rr_sched_if.master bus
);
   localparam int CW = $clog2(BURST+1);

   logic [N-1:0]  elig;
   logic [N-1:0]  urg;
   logic [SW-1:0] ptr;
   logic [SW-1:0] holder;
   logic          hold_vld;
   logic [CW-1:0] cnt;
   logic          inflight;
   logic [SW-1:0] inf_src;
   logic [DW-1:0] mem_data [2];
   logic [SW-1:0] mem_src  [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    occ;

   logic          push;
   logic          pop;
   logic          run;
   logic          issue_ok;
   logic          cont;
   logic          found;
   logic [N-1:0]  mask;
   logic [SW-1:0] win;
   logic [SW-1:0] idx;
   logic [SW-1:0] gsel;
   logic [SW-1:0] nxt;
   logic          grant;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         elig[i] = !bus.fifo_empty[i];
         urg[i]  = elig[i] &&
                   (bus.fifo_level[i*AW +: AW] >= AW'(HI_WM));
      end
   end

   assign push = inflight;
   assign pop  = bus.out_vld && bus.out_rdy;
   assign run  = rst_n && !clear;

   // Credit: buffer entries plus the word in flight, less this pop.
   assign issue_ok = ({1'b0, occ} + {2'b00, inflight}) <
                     (3'd2 + {2'b00, pop});

   always_comb begin
      cont = hold_vld && elig[holder] &&
             (cnt < CW'(BURST)) &&
             ((urg == '0) || urg[holder]);
      mask  = (|urg) ? urg : elig;
      found = 1'b0;
      win   = ptr;
      idx   = '0;
      // Descending scan so the closest index after ptr wins.
      for (int k = N-1; k >= 0; k--) begin
         idx = SW'((int'(ptr) + k) % N);
         if (mask[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      gsel  = cont ? holder : win;
      grant = run && issue_ok && (cont || found);
      nxt   = (win == SW'(N-1)) ? '0 : win + 1'b1;
      bus.fifo_rd_en = '0;
      if (grant) bus.fifo_rd_en[gsel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         ptr      <= '0;
         holder   <= '0;
         hold_vld <= 1'b0;
         cnt      <= '0;
         inflight <= 1'b0;
         inf_src  <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         occ      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem_data[i] <= '0;
            mem_src[i]  <= '0;
         end
      end else begin
         if (grant) begin
            if (cont) begin
               cnt <= cnt + CW'(1);
            end else begin
               holder   <= win;
               hold_vld <= 1'b1;
               cnt      <= CW'(1);
               ptr      <= nxt;
            end
         end
         inflight <= grant;
         inf_src  <= gsel;
         if (push) begin
            mem_data[wr_ptr] <= bus.fifo_rd_data[inf_src*DW +: DW];
            mem_src[wr_ptr]  <= inf_src;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   assign bus.out_vld  = (occ != 2'd0);
   assign bus.out_data = mem_data[rd_ptr];
   assign bus.out_src  = mem_src[rd_ptr];

   a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.fifo_rd_en));
   a_rd_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
      !(|(bus.fifo_rd_en & bus.fifo_empty)));
   a_no_overflow: assert property (@(posedge clk)
      disable iff (!rst_n || clear)
      !(push && occ == 2'd2));
endmodule

// File: tb/tb_com_fifo_rr_sched.sv
// Directed bench for com_fifo_rr_sched: per-cycle vector table plus
// hand sequences for backpressure and clear.
module tb_com_fifo_rr_sched;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int SW = 2;

   typedef struct {
      logic       rst_n;
      logic [3:0] empty;
      logic [3:0] urg;
      logic       rdy;
      logic [3:0] erd;
      logic       evld;
      logic [1:0] esrc;
      logic [31:0] edata;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   logic [31:0] tag = '0;
   int errs = 0;
   int checks = 0;
   vec_t vq[$];

   com_fifo_rr_sched_if #(.N(N), .DW(DW), .AW(AW), .SW(SW)) bus ();

   com_fifo_rr_sched #(
      .N(N), .DW(DW), .DEPTH(8), .AW(AW), .SW(SW),
      .HI_WM(6), .BURST(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clear(clear),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Registered-read RAM model: each read returns a global issue tag.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (bus.fifo_rd_en[i])
            bus.fifo_rd_data[i*DW +: DW] <= tag;
      if (|bus.fifo_rd_en) tag <= tag + 32'd1;
   end

   task automatic add(input logic r, input logic [3:0] e,
                      input logic [3:0] u, input logic rdy,
                      input logic [3:0] erd, input logic evld,
                      input logic [1:0] esrc, input logic [31:0] ed);
      vec_t v;
      v.rst_n = r; v.empty = e; v.urg = u; v.rdy = rdy;
      v.erd = erd; v.evld = evld; v.esrc = esrc; v.edata = ed;
      vq.push_back(v);
   endtask

   task automatic drive(input logic r, input logic c,
                        input logic [3:0] e, input logic [3:0] u,
                        input logic rdy);
      @(negedge clk);
      rst_n = r;
      clear = c;
      bus.fifo_empty = e;
      bus.out_rdy = rdy;
      for (int i = 0; i < N; i++)
         bus.fifo_level[i*AW +: AW] = u[i] ? 4'd6 : 4'd1;
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] erd,
                      input logic evld, input logic [1:0] esrc,
                      input logic [31:0] ed);
      checks++;
      if (bus.fifo_rd_en !== erd) begin
         errs++;
         $display("FAIL %s rd_en got %b want %b",
                  nm, bus.fifo_rd_en, erd);
      end
      checks++;
      if (bus.out_vld !== evld) begin
         errs++;
         $display("FAIL %s out_vld got %b want %b",
                  nm, bus.out_vld, evld);
      end
      if (evld) begin
         checks++;
         if (bus.out_src !== esrc) begin
            errs++;
            $display("FAIL %s out_src got %0d want %0d",
                     nm, bus.out_src, esrc);
         end
         checks++;
         if (bus.out_data !== ed) begin
            errs++;
            $display("FAIL %s out_data got %0d want %0d",
                     nm, bus.out_data, ed);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      bus.fifo_empty = '0;
      bus.fifo_level = '0;
      bus.out_rdy = 1'b1;

      // reset, then RR 0,0,1,1,2,2,3,3,0
      for (int i = 0; i < 3; i++)
         add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0010, 1, 0, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0100, 1, 1, 2);
      add(1, 4'b0000, 4'b0000, 1, 4'b0100, 1, 1, 3);
      add(1, 4'b0000, 4'b0000, 1, 4'b1000, 1, 2, 4);
      add(1, 4'b0000, 4'b0000, 1, 4'b1000, 1, 2, 5);
      add(1, 4'b0000, 4'b0000, 1, 4'b0001, 1, 3, 6);
      // urgent 2 preempts holder 0 mid-burst, then ptr=3
      add(1, 4'b0000, 4'b0100, 1, 4'b0100, 1, 3, 7);
      add(1, 4'b0000, 4'b0100, 1, 4'b0100, 1, 0, 8);
      add(1, 4'b0000, 4'b0000, 1, 4'b1000, 1, 2, 9);
      add(1, 4'b0000, 4'b0000, 1, 4'b1000, 1, 2, 10);
      // holder 1 empties after one read: 2 follows, no bubble
      add(1, 4'b0001, 4'b0000, 1, 4'b0010, 1, 3, 11);
      add(1, 4'b0011, 4'b0000, 1, 4'b0100, 1, 3, 12);
      add(1, 4'b0011, 4'b0000, 1, 4'b0100, 1, 1, 13);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 1, 2, 14);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 1, 2, 15);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst_n, 0, vq[i].empty, vq[i].urg, vq[i].rdy);
         chk($sformatf("vec%0d", i), vq[i].erd, vq[i].evld,
             vq[i].esrc, vq[i].edata);
      end

      // backpressure: two reads then stall, head held stable
      drive(1, 0, 4'b0000, 4'b0000, 0);
      chk("bp0", 4'b1000, 0, 0, 0);
      drive(1, 0, 4'b0000, 4'b0000, 0);
      chk("bp1", 4'b1000, 0, 0, 0);
      for (int i = 2; i < 5; i++) begin
         drive(1, 0, 4'b0000, 4'b0000, 0);
         chk($sformatf("bp%0d", i), 4'b0000, 1, 3, 16);
      end
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("bp5", 4'b0001, 1, 3, 16);
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("bp6", 4'b0001, 1, 3, 17);
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("bp7", 4'b0010, 1, 0, 18);
      drive(1, 0, 4'b1111, 4'b0000, 1);
      chk("bp8", 4'b0000, 1, 0, 19);
      drive(1, 0, 4'b1111, 4'b0000, 1);
      chk("bp9", 4'b0000, 1, 1, 20);
      drive(1, 0, 4'b1111, 4'b0000, 1);
      chk("bp10", 4'b0000, 0, 0, 0);

      // clear the cycle after a read: word dropped, ptr back to 0
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("clr0", 4'b0010, 0, 0, 0);
      drive(1, 1, 4'b0000, 4'b0000, 1);
      chk("clr1", 4'b0000, 0, 0, 0);
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("clr2", 4'b0001, 0, 0, 0);
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("clr3", 4'b0001, 0, 0, 0);
      drive(1, 0, 4'b0000, 4'b0000, 1);
      chk("clr4", 4'b0010, 1, 0, 22);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
